// File: rtl/real2cpx_serial.sv
// real2cpx_serial: turns a real sample stream into an analytic I/Q pair (re = centre tap, im = Hilbert FIR)
// using one shared pre-add/multiply. Define R2C_DROP_CNT_EN to add the saturating drop_cnt output.
//
// state | meaning
// IDLE  | waiting for a sample strobe
// MAC   | one coefficient pair per clock, k = 0..K-1; strobes here are dropped
// OUT   | out_valid high, re/im updated; a new sample may be accepted
module real2cpx_serial #(
    parameter int DW = 12,
    parameter int CW = 12,
    parameter int NTAPS = 15,
    localparam int K = (NTAPS + 1) / 4,
    localparam int AW = (K > 1) ? $clog2(K) : 1,
    localparam int OW = DW + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic signed [DW-1:0] in,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 out_valid,
    output logic signed [OW-1:0] re,
    output logic signed [OW-1:0] im,
    output logic                 busy,
    output logic                 overrun
`ifdef R2C_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);

    localparam int C    = (NTAPS - 1) / 2;
    localparam int PW   = CW + DW + 1;
    localparam int ACCW = DW + 1 + CW + $clog2(K);
    localparam logic signed [ACCW:0] RND  = (ACCW+1)'(2 ** (CW - 2));
    localparam logic signed [ACCW:0] SMAX = (ACCW+1)'(2 ** (OW - 1) - 1);
    localparam logic signed [ACCW:0] SMIN = (ACCW+1)'(-(2 ** (OW - 1)));

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          k_q;
    logic signed [DW-1:0]   d_q    [NTAPS];
    logic signed [CW-1:0]   coef_q [K];
    logic signed [ACCW-1:0] acc_q;
    logic                   accept;
    logic                   last;

    logic signed [DW:0]     p;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [ACCW:0]   rnd;
    logic signed [ACCW:0]   rnd_sh;
    logic signed [OW-1:0]   im_sat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE, OUT: begin
                if (en) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                if (k_q == AW'(K - 1)) begin
                    last    = 1'b1;
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == MAC);

    // Antisymmetric pair around the centre tap, then round-half-up, floor shift and saturate.
    always_comb begin
        p = '0;
        for (int i = 0; i < K; i++) begin
            if (k_q == AW'(i))
                p = OW'(d_q[C - (2 * i + 1)]) - OW'(d_q[C + (2 * i + 1)]);
        end
        prod    = PW'(coef_q[k_q]) * PW'(p);
        acc_sum = acc_q + ACCW'(prod);
        rnd     = (ACCW+1)'(acc_sum) + RND;
        rnd_sh  = rnd >>> (CW - 1);
        if (rnd_sh > SMAX)
            im_sat = {1'b0, {(OW-1){1'b1}}};
        else if (rnd_sh < SMIN)
            im_sat = {1'b1, {(OW-1){1'b0}}};
        else
            im_sat = rnd_sh[OW-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k_q       <= '0;
            acc_q     <= '0;
            re        <= '0;
            im        <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int j = 0; j < NTAPS; j++) d_q[j] <= '0;
            for (int j = 0; j < K; j++) coef_q[j] <= '0;
        end else begin
            out_valid <= last;
            // Writes in OUT land at the accept edge, before the first MAC cycle reads them.
            if (coef_we && !busy) begin
                for (int j = 0; j < K; j++) begin
                    if (coef_addr == AW'(j)) coef_q[j] <= coef_data;
                end
            end
            if (accept) begin
                d_q[0] <= in;
                for (int j = 1; j < NTAPS; j++) d_q[j] <= d_q[j-1];
                acc_q <= '0;
                k_q   <= '0;
            end else if (busy) begin
                acc_q <= acc_sum;
                k_q   <= k_q + 1'b1;
            end
            if (last) begin
                re <= OW'(d_q[C]);
                im <= im_sat;
            end
            if (en && busy) overrun <= 1'b1;
        end
    end

`ifdef R2C_DROP_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            drop_cnt <= '0;
        else if (en && busy && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_real2cpx_serial.sv
// Bench for real2cpx_serial: impulse table, hand-written corner sequences and a randomized run
// against a sample-history reference model.
module tb_real2cpx_serial;
    localparam int DW = 12, CW = 12, NTAPS = 15, K = 4, OW = 13, C = 7;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 en = 1'b0;
    logic signed [DW-1:0] in = '0;
    logic                 coef_we = 1'b0;
    logic [1:0]           coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic                 out_valid, busy, overrun;
    logic signed [OW-1:0] re, im;
`ifdef R2C_DROP_CNT_EN
    logic [7:0]           drop_cnt;
`endif

    real2cpx_serial #(.DW(DW), .CW(CW), .NTAPS(NTAPS)) dut (
        .clock(clock), .reset(reset), .en(en), .in(in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .re(re), .im(im), .busy(busy), .overrun(overrun)
`ifdef R2C_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // reference model: history of accepted samples, coefficient table, busy window after an accept
    int hist [NTAPS];
    int mcoef [K];
    int m_busy, m_drops, ecnt;
    bit m_ovr;
    bit pend_v;
    int pend_due, pend_re, pend_im;
    int cur_re, cur_im;
    bit s_ov;
    int s_re, s_im;

    typedef struct { int x; int exp_re; int exp_im; } vec_t;
    vec_t tbl [15];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int model_im();
        longint acc = 0;
        longint v;
        for (int kk = 0; kk < K; kk++)
            acc += longint'(mcoef[kk]) * longint'(hist[C - (2*kk+1)] - hist[C + (2*kk+1)]);
        v = floor_div(acc + 1024, 2048);
        if (v > 4095) v = 4095;
        if (v < -4096) v = -4096;
        return int'(v);
    endfunction

    task automatic model_clear();
        for (int j = 0; j < NTAPS; j++) hist[j] = 0;
        for (int j = 0; j < K; j++) mcoef[j] = 0;
        m_busy = 0; m_drops = 0; m_ovr = 0; pend_v = 0;
        cur_re = 0; cur_im = 0;
    endtask

    task automatic model_edge(input bit e, input int x, input bit we, input int a, input int cd);
        ecnt++;
        if (we && m_busy == 0 && a < K) mcoef[a] = cd;
        if (m_busy > 0) begin
            if (e) begin
                m_ovr = 1;
                if (m_drops < 255) m_drops++;
            end
            m_busy--;
        end else if (e) begin
            for (int j = NTAPS - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = x;
            pend_v = 1;
            pend_due = ecnt + K;
            pend_re = hist[C];
            pend_im = model_im();
            m_busy = K;
        end
    endtask

    // drive at a falling edge, let one rising edge pass, compare at the next falling edge
    task automatic tick(input bit e, input int x, input bit we = 0, input int a = 0, input int cd = 0);
        bit exp_ov;
        en = e; in = DW'(x); coef_we = we; coef_addr = 2'(a); coef_data = CW'(cd);
        model_edge(e, x, we, a, cd);
        @(posedge clock);
        @(negedge clock);
        exp_ov = pend_v && (pend_due == ecnt);
        if (exp_ov) begin
            cur_re = pend_re;
            cur_im = pend_im;
            pend_v = 0;
        end
        check("out_valid", int'(out_valid), int'(exp_ov));
        check("re", int'(re), cur_re);
        check("im", int'(im), cur_im);
        check("busy", int'(busy), int'(m_busy > 0));
        check("overrun", int'(overrun), int'(m_ovr));
`ifdef R2C_DROP_CNT_EN
        check("drop_cnt", int'(drop_cnt), m_drops);
`endif
        s_ov = out_valid; s_re = re; s_im = im;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < n; i++) begin
            en = 1'($urandom); in = DW'($urandom); coef_we = 1'($urandom);
            coef_addr = 2'($urandom); coef_data = CW'($urandom);
            @(posedge clock);
            @(negedge clock);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_re", int'(re), 0);
            check("rst_im", int'(im), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_overrun", int'(overrun), 0);
        end
        en = 1'b0; coef_we = 1'b0; in = '0;
        reset = 1'b1;
    endtask

    task automatic feed(input int x, output bit got, output int ore, output int oim);
        got = 0; ore = 0; oim = 0;
        tick(1, x);
        for (int t = 0; t < K; t++) begin
            tick(0, 0);
            if (s_ov) begin got = 1; ore = s_re; oim = s_im; end
        end
    endtask

    task automatic run_impulse();
        int lat, gr, gi, nout;
        nout = 0;
        tick(0, 0, 1, 0, 1024);
        for (int i = 0; i < 15; i++) begin
            lat = 0; gr = 0; gi = 0;
            for (int t = 1; t <= 20; t++) begin
                tick(t == 1, (t == 1) ? tbl[i].x : 0);
                if (s_ov) begin
                    nout++;
                    if (lat == 0) begin lat = t; gr = s_re; gi = s_im; end
                end
            end
            check($sformatf("imp_latency[%0d]", i), lat, K + 1);
            check($sformatf("imp_re[%0d]", i), gr, tbl[i].exp_re);
            check($sformatf("imp_im[%0d]", i), gi, tbl[i].exp_im);
        end
        check("imp_out_count", nout, 15);
    endtask

    initial begin
        bit g;
        int r_re, r_im, nout;

        for (int i = 0; i < 15; i++) begin
            tbl[i].x      = (i == 0) ? 1000 : 0;
            tbl[i].exp_re = (i == 7) ? 1000 : 0;
            tbl[i].exp_im = (i == 6) ? 500 : ((i == 8) ? -500 : 0);
        end
        ecnt = 0;
        @(negedge clock);

        do_reset(8);
        run_impulse();

        // saturation: all coefficients full-scale, 8 x 2047 then 7 x -2048
        do_reset(2);
        for (int kk = 0; kk < K; kk++) tick(0, 0, 1, kk, 2047);
        r_re = 0; r_im = 0;
        for (int i = 0; i < 15; i++) feed((i < 8) ? 2047 : -2048, g, r_re, r_im);
        check("sat_valid", int'(g), 1);
        check("sat_im", r_im, -4096);
        check("sat_re", r_re, 2047);

        // cadence K+1: nothing dropped
        do_reset(2);
        nout = 0;
        for (int i = 0; i < 8; i++) begin
            feed(int'($urandom_range(0, 4095)) - 2048, g, r_re, r_im);
            if (g) nout++;
        end
        check("cad5_outputs", nout, 8);
        check("cad5_overrun", int'(overrun), 0);

        // cadence K: every second strobe dropped
        do_reset(2);
        nout = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1, int'($urandom_range(0, 4095)) - 2048);
            if (s_ov) nout++;
            for (int t = 0; t < K - 1; t++) begin tick(0, 0); if (s_ov) nout++; end
        end
        for (int t = 0; t < 6; t++) begin tick(0, 0); if (s_ov) nout++; end
        check("cad4_outputs", nout, 4);
        check("cad4_overrun", int'(overrun), 1);
`ifdef R2C_DROP_CNT_EN
        check("cad4_drop_cnt", int'(drop_cnt), 4);
`endif

        // coefficient write during MAC is ignored, the same write in IDLE lands
        do_reset(2);
        tick(0, 0, 1, 0, 1024);
        tick(1, 1000);
        tick(0, 0, 1, 1, 500);
        for (int t = 0; t < K - 1; t++) tick(0, 0);
        for (int i = 0; i < 4; i++) feed(0, g, r_re, r_im);
        check("busy_write_ignored_im", r_im, 0);
        tick(0, 0, 1, 1, 500);
        for (int i = 0; i < 10; i++) feed(0, g, r_re, r_im);
        feed(1000, g, r_re, r_im);
        for (int i = 0; i < 4; i++) feed(0, g, r_re, r_im);
        check("idle_write_used_im", r_im, 244);

        // write coinciding with accept is used by that computation
        do_reset(2);
        tick(1, 1000, 1, 3, 1024);
        g = 0; r_im = 0;
        for (int t = 0; t < K; t++) begin tick(0, 0); if (s_ov) begin g = 1; r_im = s_im; end end
        check("accept_write_valid", int'(g), 1);
        check("accept_write_im", r_im, 500);

        // reset two cycles after accept: aborted, and the impulse response is reproduced afterwards
        do_reset(2);
        tick(0, 0, 1, 0, 1024);
        tick(1, 777);
        tick(0, 0);
        do_reset(3);
        nout = 0;
        for (int t = 0; t < 8; t++) begin tick(0, 0); if (s_ov) nout++; end
        check("abort_no_output", nout, 0);
        run_impulse();

        // randomized traffic: strobes, coefficient writes (some while busy), full-range samples
        do_reset(3);
        for (int i = 0; i < 3000; i++) begin
            bit e, we;
            e  = ($urandom_range(0, 2) == 0);
            we = ($urandom_range(0, 7) == 0);
            tick(e, int'($urandom_range(0, 4095)) - 2048, we,
                 int'($urandom_range(0, K - 1)), int'($urandom_range(0, 4095)) - 2048);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
